// File: rtl/branch_outcome_queue.sv
// branch_outcome_queue
//   Tracks predicted branches from fetch until execute reports their actual
//   direction. It then retires them strictly in allocation order and produces
//   one training pulse per branch for the direction predictor.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   alloc_valid/pc/pred   fetch allocates a predicted branch
//   alloc_ready, alloc_tag  queue has room; slot index for this allocation
//   resolve_valid/tag/taken execute reports the actual outcome of a slot
//   flush                 discard every in-flight entry
//   upd_valid/pc/taken    registered one-cycle training pulse for the predictor
//   mispredict            retiring branch was predicted wrongly
//   count                 number of in-flight entries
//   mispredict_count      saturating total of retired mispredicts
//   resolve_err           sticky flag set by any illegal resolve
module branch_outcome_queue #(
  parameter int DEPTH    = 8,
  parameter int PTR_BITS = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                alloc_valid,
  input  logic [31:0]         alloc_pc,
  input  logic                alloc_pred,
  output logic                alloc_ready,
  output logic [PTR_BITS-1:0] alloc_tag,
  input  logic                resolve_valid,
  input  logic [PTR_BITS-1:0] resolve_tag,
  input  logic                resolve_taken,
  input  logic                flush,
  output logic                upd_valid,
  output logic [31:0]         upd_pc,
  output logic                upd_taken,
  output logic                mispredict,
  output logic [PTR_BITS:0]   count,
  output logic [15:0]         mispredict_count,
  output logic                resolve_err
);

  localparam logic [PTR_BITS:0] FULL = (PTR_BITS+1)'(DEPTH);

  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    resolved_q;
  logic [DEPTH-1:0]    pred_q;
  logic [DEPTH-1:0]    taken_q;
  logic [31:0]         pc_q [DEPTH];
  logic [PTR_BITS-1:0] head;
  logic [PTR_BITS-1:0] tail;

  logic do_alloc;
  logic resolve_ok;
  logic do_retire;
  logic head_misp;

  // Readiness looks only at the registered count, so a retire in the same
  // cycle never frees a slot early.
  assign alloc_ready = (count < FULL);
  assign alloc_tag   = tail;
  assign do_alloc    = alloc_valid && alloc_ready;

  // A slot being allocated this cycle is still invalid in the registered
  // state, so a resolve aimed at it is rejected by the same check.
  assign resolve_ok  = valid_q[resolve_tag] && !resolved_q[resolve_tag];
  assign do_retire   = valid_q[head] && resolved_q[head];
  assign head_misp   = pred_q[head] ^ taken_q[head];

  // Entry storage and pointers. Head and tail never collide on a write:
  // allocation is blocked when full, and retire needs a valid head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= '0;
      resolved_q <= '0;
      pred_q     <= '0;
      taken_q    <= '0;
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      valid_q    <= '0;
      resolved_q <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else begin
      if (do_retire) begin
        valid_q[head]    <= 1'b0;
        resolved_q[head] <= 1'b0;
        head             <= head + PTR_BITS'(1);
      end
      if (resolve_valid && resolve_ok) begin
        resolved_q[resolve_tag] <= 1'b1;
        taken_q[resolve_tag]    <= resolve_taken;
      end
      if (do_alloc) begin
        valid_q[tail]    <= 1'b1;
        resolved_q[tail] <= 1'b0;
        pc_q[tail]       <= alloc_pc;
        pred_q[tail]     <= alloc_pred;
        tail             <= tail + PTR_BITS'(1);
      end
      if (do_alloc && !do_retire)
        count <= count + (PTR_BITS+1)'(1);
      else if (!do_alloc && do_retire)
        count <= count - (PTR_BITS+1)'(1);
    end
  end

  // Training outputs. The payload holds its last value between pulses;
  // flush only silences the pulse and the mispredict flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_valid        <= 1'b0;
      upd_pc           <= 32'h0;
      upd_taken        <= 1'b0;
      mispredict       <= 1'b0;
      mispredict_count <= 16'h0;
      resolve_err      <= 1'b0;
    end else if (flush) begin
      upd_valid  <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      upd_valid <= do_retire;
      if (do_retire) begin
        upd_pc     <= pc_q[head];
        upd_taken  <= taken_q[head];
        mispredict <= head_misp;
        if (head_misp && (mispredict_count != 16'hFFFF))
          mispredict_count <= mispredict_count + 16'd1;
      end
      if (resolve_valid && !resolve_ok)
        resolve_err <= 1'b1;
    end
  end

endmodule

// File: doc/branch_outcome_queue.md
BRANCH_OUTCOME_QUEUE -- requirements
Module: branch_outcome_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of in-flight branch entries (power of 2, >=2).
REQ-002 Parameter PTR_BITS, default 3, log2(DEPTH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 alloc_valid  input  1  fetch presents a predicted branch this cycle.
REQ-006 alloc_pc  input  32  PC of the allocated branch.
REQ-007 alloc_pred  input  1  direction predicted at fetch (1 = taken).
REQ-008 alloc_ready  output  1  queue can accept an allocation.
REQ-009 alloc_tag  output  PTR_BITS  slot index given to the current allocation (= tail pointer).
REQ-010 resolve_valid  input  1  execute reports an actual outcome.
REQ-011 resolve_tag  input  PTR_BITS  slot being resolved.
REQ-012 resolve_taken  input  1  actual direction.
REQ-013 flush  input  1  discard all in-flight entries.
REQ-014 upd_valid  output  1  one-cycle training pulse; drives predictor branch_valid and is_branch.
REQ-015 upd_pc  output  32  PC of the retiring branch; drives predictor pc.
REQ-016 upd_taken  output  1  actual outcome of the retiring branch; drives predictor branch_taken.
REQ-017 mispredict  output  1  retiring branch had alloc_pred != actual outcome.
REQ-018 count  output  PTR_BITS+1  number of valid entries.
REQ-019 mispredict_count  output  16  saturating total of mispredicts.
REQ-020 resolve_err  output  1  sticky flag for an illegal resolve.

Function
REQ-021 Per entry, state SHALL be: valid, resolved, pc[31:0], pred, taken.
REQ-022 Entries SHALL be kept in a circular buffer with head (oldest) and tail pointers of PTR_BITS bits, wrapping from DEPTH-1 to 0.
REQ-023 alloc_ready SHALL be 1 exactly when the registered count < DEPTH, independent of any retire in the same cycle.
REQ-024 alloc_tag SHALL equal the tail pointer combinationally.
REQ-025 An allocation SHALL occur at the edge where alloc_valid && alloc_ready; it writes pc and pred, sets valid=1, clears resolved, and increments tail.
REQ-026 alloc_valid while alloc_ready=0 SHALL be ignored with no state change.
REQ-027 A resolve SHALL set resolved=1 and taken=resolve_taken only if slot resolve_tag is valid and not yet resolved.
REQ-028 Any other resolve, including one to a slot allocated in the same cycle, SHALL be dropped and SHALL set resolve_err=1 until reset.
REQ-029 Retire SHALL occur at an edge where the head entry is valid and resolved, both as registered.
REQ-030 On retire, the head entry SHALL be cleared, head incremented, and upd_valid/upd_pc/upd_taken/mispredict registered from it, so they are visible for exactly the following cycle.
REQ-031 At most one retire per cycle; retirement SHALL be strictly in allocation order, so younger resolved entries wait for the head.
REQ-032 Latency: a resolve of the head presented in cycle N SHALL produce upd_valid=1 in cycle N+2.
REQ-033 count SHALL be updated +1 on allocate only, -1 on retire only, and unchanged on both; it SHALL never exceed DEPTH or fall below 0.
REQ-034 mispredict_count SHALL increment on each retire with mispredict=1, hold at 16'hFFFF, and be cleared only by reset.
REQ-035 upd_valid=0 SHALL force upd_pc, upd_taken and mispredict to their previous values; consumers qualify them with upd_valid.
REQ-036 flush SHALL have priority over allocate, resolve and retire in the same cycle.
REQ-037 flush SHALL clear every valid/resolved bit, set head=tail=0 and count=0, and register upd_valid=0 and mispredict=0.
REQ-038 flush SHALL leave mispredict_count and resolve_err unchanged.

Reset
REQ-039 reset_n=0 SHALL immediately, without a clock, clear all entries, pointers and count; set upd_valid, upd_taken, mispredict, resolve_err and mispredict_count to 0 and upd_pc to 32'h0.
REQ-040 During and after reset, alloc_ready SHALL be 1 and alloc_tag SHALL be 0.
REQ-041 Reset asserted mid-operation SHALL discard in-flight entries with no upd_valid pulse.
REQ-042 The first edge after reset_n rises SHALL be a normal operating edge.

Verification
REQ-043 Alloc pc=0x100 pred=1, then resolve tag0 taken=0 in cycle N -> in cycle N+2: upd_valid=1, upd_pc=0x100, upd_taken=0, mispredict=1, then mispredict_count=1.
REQ-044 Alloc tags 0,1,2; resolve 2, then 1, then 0 -> upd pulses in order of pc tag0, tag1, tag2 on three consecutive cycles after tag0 resolves.
REQ-045 Allocate 8 times with no resolves -> count=8, alloc_ready=0; a 9th alloc_valid is ignored; retire one -> alloc_ready=1 and the next alloc_tag=0 (wrap).
REQ-046 Resolve an unallocated tag, then resolve an already-resolved tag -> no state change, resolve_err=1 and it stays set.
REQ-047 With 4 entries valid and the head resolved, assert flush together with alloc_valid -> count=0, no upd_valid pulse, and the allocation is dropped.
REQ-048 Pulse reset_n low asynchronously mid-stream with 3 entries valid -> outputs reach reset values before the next edge, and mispredict_count=0.
